// File: rtl/axi4_pkg.sv
// Shared AXI4 address-channel definitions: fixed field widths and the
// LSB offsets of each field inside a packed AX payload. The payload is
// packed MSB to LSB as addr, len, size, burst, lock, cache, prot, qos,
// region, id, user, so everything below addr totals AX_FIXED_W + id width.
package axi4_pkg;

  localparam int unsigned LEN_W      = 8;
  localparam int unsigned SIZE_W     = 3;
  localparam int unsigned BURST_W    = 2;
  localparam int unsigned LOCK_W     = 1;
  localparam int unsigned CACHE_W    = 4;
  localparam int unsigned PROT_W     = 3;
  localparam int unsigned QOS_W      = 4;
  localparam int unsigned REGION_W   = 4;
  localparam int unsigned USER_W     = 1;
  localparam int unsigned AX_FIXED_W = 30;

  // Field LSB offsets, counted from bit 0 of the packed payload.
  function automatic int unsigned user_lsb();
    return 0;
  endfunction

  function automatic int unsigned id_lsb();
    return USER_W;
  endfunction

  function automatic int unsigned region_lsb(input int unsigned id_w);
    return USER_W + id_w;
  endfunction

  function automatic int unsigned qos_lsb(input int unsigned id_w);
    return region_lsb(id_w) + REGION_W;
  endfunction

  function automatic int unsigned prot_lsb(input int unsigned id_w);
    return qos_lsb(id_w) + QOS_W;
  endfunction

  function automatic int unsigned cache_lsb(input int unsigned id_w);
    return prot_lsb(id_w) + PROT_W;
  endfunction

  function automatic int unsigned lock_lsb(input int unsigned id_w);
    return cache_lsb(id_w) + CACHE_W;
  endfunction

  function automatic int unsigned burst_lsb(input int unsigned id_w);
    return lock_lsb(id_w) + LOCK_W;
  endfunction

  function automatic int unsigned size_lsb(input int unsigned id_w);
    return burst_lsb(id_w) + BURST_W;
  endfunction

  function automatic int unsigned len_lsb(input int unsigned id_w);
    return size_lsb(id_w) + SIZE_W;
  endfunction

  function automatic int unsigned addr_lsb(input int unsigned id_w);
    return len_lsb(id_w) + LEN_W;
  endfunction

endpackage

// File: rtl/axi4_queue_ptr.sv
// Circular-buffer pointer that steps 0..DEPTH-1 and wraps to 0, for any
// DEPTH including non-powers of two. With DEPTH=1 it stays at 0.
//   clk   : clock
//   reset : synchronous active-high, returns pointer to 0
//   adv   : advance by one this cycle
//   ptr   : current pointer value
module axi4_queue_ptr #(
  parameter int unsigned DEPTH = 2,
  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             adv,
  output logic [PTR_W-1:0] ptr
);

  // Wrap explicitly at DEPTH-1 rather than relying on natural overflow.
  always_ff @(posedge clk) begin
    if (reset) begin
      ptr <= '0;
    end else if (adv) begin
      if (ptr == PTR_W'(DEPTH - 1)) ptr <= '0;
      else                          ptr <= ptr + PTR_W'(1);
    end
  end

endmodule

// File: rtl/axi4_ax_queue.sv
// AXI4 address-channel queue: DEPTH-entry circular buffer of packed AX beats
// with valid/ready handshakes on both sides.
//   clk, reset           : clock, synchronous active-high reset
//   enq_valid/ready/bits : producer side
//   deq_valid/ready/bits : consumer side, head read combinationally
//   count                : occupied entries
// PIPE=1 lets a full queue accept while the head is being taken.
// Optional AXI4_AX_QUEUE_FLOW_EN: an empty queue forwards enq straight to
// deq in the same cycle; a beat consumed that way is never stored.
module axi4_ax_queue
  import axi4_pkg::*;
#(
  parameter int unsigned DEPTH  = 2,
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned ID_W   = 5,
  parameter int unsigned PIPE   = 0,
  localparam int unsigned AX_W  = ADDR_W + ID_W + AX_FIXED_W,
  localparam int unsigned CNT_W = $clog2(DEPTH + 1),
  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enq_valid,
  output logic             enq_ready,
  input  logic [AX_W-1:0]  enq_bits,
  output logic             deq_valid,
  input  logic             deq_ready,
  output logic [AX_W-1:0]  deq_bits,
  output logic [CNT_W-1:0] count
);

  logic [AX_W-1:0]  mem [DEPTH];
  logic [PTR_W-1:0] wptr;
  logic [PTR_W-1:0] rptr;
  logic             empty;
  logic             wr;
  logic             rd;

  assign empty     = (count == '0);
  assign enq_ready = (count != CNT_W'(DEPTH)) || ((PIPE != 0) && deq_ready);

`ifdef AXI4_AX_QUEUE_FLOW_EN
  // Empty queue: present the incoming beat directly; if it is taken now,
  // neither storage nor count changes.
  assign deq_valid = !empty || enq_valid;
  assign deq_bits  = empty ? enq_bits : mem[rptr];
  assign wr        = enq_valid && enq_ready && !(empty && deq_ready);
  assign rd        = deq_ready && !empty;
`else
  assign deq_valid = !empty;
  assign deq_bits  = mem[rptr];
  assign wr        = enq_valid && enq_ready;
  assign rd        = deq_valid && deq_ready;
`endif

  axi4_queue_ptr #(.DEPTH(DEPTH)) u_wptr (
    .clk   (clk),
    .reset (reset),
    .adv   (wr),
    .ptr   (wptr)
  );

  axi4_queue_ptr #(.DEPTH(DEPTH)) u_rptr (
    .clk   (clk),
    .reset (reset),
    .adv   (rd),
    .ptr   (rptr)
  );

  // Storage is not reset; contents are only observable once count > 0.
  always_ff @(posedge clk) begin
    if (wr) mem[wptr] <= enq_bits;
  end

  // Occupancy: simultaneous write and read leave it unchanged.
  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (wr && !rd) begin
      count <= count + CNT_W'(1);
    end else if (rd && !wr) begin
      count <= count - CNT_W'(1);
    end
  end

endmodule

// File: doc/axi4_ax_queue.md
AXI4_AX_QUEUE -- requirements
Module: axi4_ax_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 2, number of entries (legal range 1..64, any integer).
REQ-002 SHALL have parameter ADDR_W, default 32, address field width.
REQ-003 SHALL have parameter ID_W, default 5, id field width.
REQ-004 SHALL have parameter PIPE, default 0; when 1, enq_ready is also asserted while full if deq_ready is 1.
REQ-005 SHALL define derived width AX_W = ADDR_W + ID_W + 30.
REQ-006 SHALL have port clk, input, 1, clock; all state changes on its rising edge.
REQ-007 SHALL have port reset, input, 1, synchronous, active-high reset.
REQ-008 SHALL have port enq_valid, input, 1, producer holds a beat.
REQ-009 SHALL have port enq_ready, output, 1, queue accepts a beat this cycle.
REQ-010 SHALL have port enq_bits, input, AX_W, packed AX payload.
REQ-011 SHALL have port deq_valid, output, 1, head entry present.
REQ-012 SHALL have port deq_ready, input, 1, consumer takes the head.
REQ-013 SHALL have port deq_bits, output, AX_W, head payload.
REQ-014 SHALL have port count, output, $clog2(DEPTH+1), number of occupied entries.
REQ-015 SHALL pack enq_bits/deq_bits MSB to LSB as: addr, len[8], size[3], burst[2], lock[1], cache[4], prot[3], qos[4], region[4], id, user[1].

Function
REQ-016 SHALL perform an enqueue (do_enq) when enq_valid & enq_ready, and a dequeue (do_deq) when deq_valid & deq_ready.
REQ-017 SHALL drive enq_ready = (count != DEPTH) | (PIPE & deq_ready).
REQ-018 SHALL drive deq_valid = (count != 0), except as modified by REQ-033.
REQ-019 SHALL store entries in a circular buffer with wptr and rptr, each ranging 0..DEPTH-1 and wrapping from DEPTH-1 to 0. This includes non-power-of-2 DEPTH.
REQ-020 SHALL write enq_bits at wptr on do_enq and advance wptr by 1.
REQ-021 SHALL advance rptr by 1 on do_deq.
REQ-022 SHALL drive deq_bits combinationally from the entry at rptr, giving zero added latency after the write cycle. An enqueued beat is visible on deq one cycle after do_enq.
REQ-023 SHALL update count as: +1 on do_enq only, -1 on do_deq only, and unchanged on both or neither.
REQ-024 SHALL, on simultaneous do_enq and do_deq at count 0 < n < DEPTH, leave count at n and advance both pointers.
REQ-025 SHALL, when full with PIPE=1 and deq_ready=1, accept the new beat and keep count at DEPTH.
REQ-026 SHALL, with DEPTH=1, reduce the pointers to constant 0 and behave as a single-entry holding register.
REQ-027 SHALL never advance count past DEPTH or below 0; enq_valid while not ready and deq_ready while empty SHALL have no effect.
REQ-028 SHALL hold deq_bits stable while deq_valid=1 and deq_ready=0.

Reset
REQ-029 SHALL, while reset=1 at a clock edge, set count=0, wptr=0 and rptr=0, giving deq_valid=0 and enq_ready=1 on the next cycle.
REQ-030 SHALL not reset storage contents; deq_bits is don't-care while deq_valid=0.
REQ-031 SHALL, on reset asserted mid-operation, discard all queued beats, with the reset taking priority over a simultaneous do_enq or do_deq.

Configuration
REQ-032 SHALL support macro AXI4_AX_QUEUE_FLOW_EN.
REQ-033 SHALL, with AXI4_AX_QUEUE_FLOW_EN defined and count=0, bypass combinationally: deq_valid=enq_valid and deq_bits=enq_bits. If deq_ready=1, the beat is consumed the same cycle without being written and count stays 0.
REQ-034 SHALL, without AXI4_AX_QUEUE_FLOW_EN, have no combinational path from enq_* to deq_*.

Structure
REQ-035 SHALL place in shared package axi4_pkg: the field widths (LEN_W=8, SIZE_W=3, BURST_W=2, CACHE_W=4, PROT_W=3, QOS_W=4, REGION_W=4, USER_W=1), the constant AX_FIXED_W=30, and the field-offset functions for unpacking.
REQ-036 SHALL implement the pointer wrap in one sub-module, axi4_queue_ptr, instantiated twice (once for wptr, once for rptr).

Verification
REQ-037 SHALL verify fill and drain: DEPTH=2, PIPE=0, enqueue addr 0x1000 then 0x2000 with deq_ready=0 -> count=2 and enq_ready=0; then deq_ready=1 -> 0x1000 then 0x2000 in order, ending at count=0.
REQ-038 SHALL verify simultaneous transfer: count=1 with do_enq and do_deq in the same cycle -> count stays 1 and the head becomes the new beat.
REQ-039 SHALL verify PIPE full-accept: PIPE=1, full, enq_valid=1, deq_ready=1 -> enq_ready=1 and count stays 2.
REQ-040 SHALL verify wrap at DEPTH=3: 10 sequential beats with ids 0..9 -> all dequeued in order and no loss across the pointer wrap.
REQ-041 SHALL verify reset mid-operation: count=2, reset pulsed for 1 cycle -> count=0, deq_valid=0, enq_ready=1.
REQ-042 SHALL verify flow mode: with AXI4_AX_QUEUE_FLOW_EN defined, empty queue, enq_valid=1 with id=0x1F and deq_ready=1 -> same-cycle deq_valid=1, deq id=0x1F, and count stays 0.
